// File: rtl/bcd_pair_to_bin.sv
// bcd_pair_to_bin
// Turns a two-digit decimal entry (tens strobe, then units strobe) into a
// 6-bit binary value for the settable time/counter registers. This is the
// inverse of the binary-to-two-digit display decoder.
//
// Ports:
//   clk          - system clock, all logic on the rising edge
//   reset        - synchronous active-high reset
//   digit_in     - BCD digit, sampled only while digit_valid is high
//   digit_valid  - single-cycle strobe qualifying digit_in
//   clear        - synchronous abort, drops any partial entry
//   number       - last successfully converted value, held between entries
//   number_valid - one-cycle pulse when number is updated
//   error        - one-cycle pulse on a bad digit or an out-of-range result
//   tens_pending - a tens digit is stored and units are awaited
//   busy         - conversion cycle in progress, strobes are ignored
module bcd_pair_to_bin #(
    parameter int MAX_VALUE = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       clear,
    output logic [5:0] number,
    output logic       number_valid,
    output logic       error,
    output logic       tens_pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_UNITS = 2'd1,
        CALC       = 2'd2
    } state_t;

    localparam logic [6:0] MAX_LIMIT = 7'(MAX_VALUE);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic [5:0] number_q, number_d;
    logic       number_valid_q, number_valid_d;
    logic       error_q, error_d;
    logic [6:0] sum;
    logic       digit_ok;

    // tens*10 + units built from shifts; 99 at most, so 7 bits never overflow.
    assign sum = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1) + {3'b000, units_q};
    assign digit_ok = (digit_in <= 4'd9);

    // State register and all registered outputs. The result pulses are
    // recomputed every cycle, so they fall back to zero on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            tens_q         <= 4'd0;
            units_q        <= 4'd0;
            number_q       <= 6'd0;
            number_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            tens_q         <= tens_d;
            units_q        <= units_d;
            number_q       <= number_d;
            number_valid_q <= number_valid_d;
            error_q        <= error_d;
        end
    end

    // Next-state logic. clear outranks everything except reset: it returns
    // to IDLE and also swallows the result of a CALC cycle. Strobes seen
    // during CALC are dropped without an error.
    always_comb begin
        state_d        = state_q;
        tens_d         = tens_q;
        units_d        = units_q;
        number_d       = number_q;
        number_valid_d = 1'b0;
        error_d        = 1'b0;

        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (digit_valid) begin
                        if (digit_ok) begin
                            tens_d  = digit_in;
                            state_d = WAIT_UNITS;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                WAIT_UNITS: begin
                    if (digit_valid) begin
                        if (digit_ok) begin
                            units_d = digit_in;
                            state_d = CALC;
                        end else begin
                            tens_d  = 4'd0;
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                CALC: begin
                    if (sum <= MAX_LIMIT) begin
                        number_d       = sum[5:0];
                        number_valid_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign number       = number_q;
    assign number_valid = number_valid_q;
    assign error        = error_q;
    assign tens_pending = (state_q == WAIT_UNITS);
    assign busy         = (state_q == CALC);

endmodule

// File: doc/bcd_pair_to_bin.md
# bcd_pair_to_bin

Converts a two-digit decimal entry, delivered as two sequential BCD digit strobes (tens first, then units), into a 6-bit binary value for the time/counter registers of the VGA monitor. It is the inverse of the binary-to-two-digit display decoder: the display path goes binary to digits, and this block takes user digit entry back to binary. It sits between the digit-entry front end and the settable time registers.

## Interface

- `MAX_VALUE`, default 59: largest value accepted. Legal range 0..63.
- `clk`, input, 1: system clock. All logic is rising-edge.
- `reset`, input, 1: synchronous, active-high reset.
- `digit_in`, input, 4: BCD digit. Sampled only when `digit_valid`=1.
- `digit_valid`, input, 1: single-cycle strobe qualifying `digit_in`.
- `clear`, input, 1: synchronous abort. Discards any partial entry.
- `number`, output, 6: last successfully converted value. Holds between conversions.
- `number_valid`, output, 1: one-cycle pulse when `number` is updated.
- `error`, output, 1: one-cycle pulse on a rejected digit or an out-of-range result.
- `tens_pending`, output, 1: a tens digit is stored and the block is waiting for units.
- `busy`, output, 1: conversion in progress. Strobes are ignored while high.

## Operation

- FSM states: IDLE, WAIT_UNITS, CALC.
- IDLE
  - `digit_valid` with `digit_in`≤9: store it in `tens_q`, go to WAIT_UNITS.
  - `digit_valid` with `digit_in`>9: pulse `error`, stay in IDLE.
- WAIT_UNITS
  - `digit_valid` with `digit_in`≤9: store it in `units_q`, go to CALC.
  - `digit_valid` with `digit_in`>9: pulse `error`, discard `tens_q`, go to IDLE.
  - No timeout. The block waits indefinitely.
- CALC (exactly one cycle)
  - Compute `sum = (tens_q<<3) + (tens_q<<1) + units_q` in 7 bits (maximum 99, no overflow).
  - If `sum` ≤ `MAX_VALUE`: `number` <= `sum[5:0]` and pulse `number_valid`.
  - Otherwise: pulse `error` and leave `number` unchanged.
  - Always return to IDLE.
- Strobes in CALC are dropped silently. There is no error pulse and no queuing.
- Priority: `reset` > `clear` > `digit_valid`.
- `clear` in any state:
  - Go to IDLE on the next edge.
  - Suppress the pending `number_valid`/`error` of a CALC cycle.
  - `number` is unchanged.
- `number_valid` and `error` are never high in the same cycle.
- Combinational outputs:
  - `tens_pending` = (state==WAIT_UNITS).
  - `busy` = (state==CALC).
- Reset values:
  - state = IDLE.
  - `number` = 0.
  - `number_valid`, `error`, `tens_pending`, `busy` = 0.
  - `tens_q` and `units_q` = 0.

## Timing

- Tens strobe sampled at edge E0: `tens_pending`=1 from after E0.
- Units strobe sampled at edge E1:
  - `busy`=1 and `tens_pending`=0 in the cycle after E1.
  - At edge E1+1, `number`/`number_valid` (or `error`) register. The pulse is high for the cycle after E1+1.
  - Total latency from the units strobe to the result is 2 edges.
- Digit-range error: `error` is high for the single cycle following the offending strobe edge.
- Back-to-back entries:
  - A new tens strobe is accepted in the cycle in which `number_valid` is high (the state is already IDLE).
  - The minimum entry period is 3 cycles.
- Reset asserted mid-entry or during CALC: all outputs take their reset values after that edge, with no pulse.
- `clear` coincident with `digit_valid`: `clear` wins and the digit is discarded.

## Test plan

- Reset, then tens=4 and units=2 on consecutive cycles -> `number`=42 (6'b101010), `number_valid` pulses one cycle, 2 edges after the units strobe; `error` stays 0.
- Tens=6, units=0, `MAX_VALUE`=59 -> `error` pulses one cycle, `number` keeps its previous value (42), `number_valid` stays 0; repeat with `MAX_VALUE`=63 -> `number`=60.
- Tens=`4'hA` -> `error` pulses, `tens_pending` stays 0; then tens=1 and units=`4'hF` -> `error` pulses, state returns to IDLE; then 0,9 -> `number`=9.
- Tens=3, `clear`, then units=5 -> no result; the 5 is taken as a new tens digit and `tens_pending`=1.
- Tens=2, units=3, with `digit_valid`=7 driven during the CALC cycle -> `number`=23; the 7 is ignored and `tens_pending`=0 afterwards.
- Tens=5, then `reset` asserted in the CALC cycle after units=9 -> `number`=0 and no `number_valid`/`error` pulse; a following 0,0 entry -> `number`=0 with a `number_valid` pulse.
